fir_tap_sequencer: RTL and testbench

- Controls the 66-deep 32-bit sample history buffer used by the filter path.
- For each accepted input sample, it pushes the sample into the buffer and walks every tap address. It multiply-accumulates each history word with a coefficient from an external coefficient ROM, then emits one rounded, scaled filter output.
- Sits between the sensor/ADC sample source and the motor-control consumer of filtered values.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_mac.sv | 104 ++++++++++
 rtl/fir_tap_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR tap sequencer slice:
//   - default widths/depths (DEF_*), used as parameter defaults by the modules
//   - sequencer state encoding
//   - rounding-constant helper for the round-half-up output stage
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int DEF_TAPS  = 66;  // history entries / coefficients
  localparam int DEF_DW    = 32;  // sample and output width (signed)
  localparam int DEF_CW    = 16;  // coefficient width (signed Q1.15)
  localparam int DEF_AW    = 7;   // history / coefficient address width
  localparam int DEF_ACC_W = 56;  // accumulator width, >= DW+CW+AW
  localparam int DEF_SHIFT = 15;  // output right-shift

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MAC    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_OUT    = 3'd5
  } fir_state_e;

  // Half an output LSB, added before the arithmetic shift so that the
  // shift rounds half up instead of flooring.
  function automatic logic [63:0] round_k(input int shift);
    return 64'd1 << (shift - 1);
  endfunction

  // Rounding constant for the default configuration.
  localparam logic [63:0] DEF_ROUND_K = 64'd1 << (DEF_SHIFT - 1);

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Signed multiply-accumulate with synchronous clear and enable, followed by
// the round / shift / (optional) saturate stage that produces the filter
// output word.
//
// y_next is derived from the accumulator's *next* value so that the owner
// can register the final result in the same cycle the last product lands.
//
// Build option: FIR_SAT_EN - when defined the shifted result saturates to the
// signed DW range; otherwise the low DW bits are kept (two's-complement wrap).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear accumulator (has priority over en)
//   en          accumulate a*b this cycle
//   a           signed DW-bit history word
//   b           signed CW-bit coefficient
//   y_next      rounded/shifted result of the next accumulator value
// -----------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [DW-1:0] y_next
);

  localparam int PW = DW + CW;
  localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(round_k(SHIFT));

  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shifted_s;

  // Full-precision signed product, sign-extended to the accumulator width.
  always_comb begin
    prod_s     = $signed(a) * $signed(b);
    prod_ext_s = {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
  end

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef FIR_SAT_EN
  logic [ACC_W-DW:0] upper_s;

  // Round half up, shift, then clamp to the signed DW range. The value fits
  // when every bit from the DW-1 sign position upward agrees.
  always_comb begin
    sum_s     = acc_d + RND_K;
    shifted_s = sum_s >>> SHIFT;
    upper_s   = shifted_s[ACC_W-1:DW-1];
    if ((&upper_s) || !(|upper_s)) begin
      y_next = shifted_s[DW-1:0];
    end else if (shifted_s[ACC_W-1]) begin
      y_next = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_next = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic unused_hi_s;

  // Round half up, shift, then wrap to the low DW bits.
  always_comb begin
    sum_s       = acc_d + RND_K;
    shifted_s   = sum_s >>> SHIFT;
    y_next      = shifted_s[DW-1:0];
    unused_hi_s = ^shifted_s[ACC_W-1:DW];
  end
`endif

endmodule

// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
// Sequences one FIR evaluation per accepted sample: pushes the sample into an
// external TAPS-deep history buffer, walks every tap address against an
// external coefficient ROM (both 1-cycle read latency), multiply-accumulates
// through fir_mac and emits one rounded, scaled result.
//
// Build option: FIR_SAT_EN (see fir_mac) - saturating instead of wrapping
// output.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_valid  one-cycle strobe, sample_in valid
//   sample_in     new signed sample (DW)
//   hist_en       history shift enable, one-cycle high pulse per push
//   hist_din      sample pushed into the history buffer
//   hist_addr     history read address
//   hist_dout     history read data (1-cycle latency)
//   coef_addr     coefficient ROM address, always equal to hist_addr
//   coef_data     coefficient data (1-cycle latency)
//   y_out         filter result, held until the next result
//   y_valid       one-cycle pulse when y_out updates
//   busy          high in every state except IDLE
//   overrun       high in the same cycle a sample is dropped while busy
//
// Timing with sample_valid accepted in cycle 0: hist_en in cycle 1, address 0
// in cycles 2..3 (SETTLE, first MAC), address TAPS-1 in cycle TAPS+2,
// y_valid in cycle TAPS+4, next sample accepted from cycle TAPS+5.
// -----------------------------------------------------------------------------
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS  = DEF_TAPS,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int AW    = DEF_AW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic          hist_en,
  output logic [DW-1:0] hist_din,
  output logic [AW-1:0] hist_addr,
  input  logic [DW-1:0] hist_dout,
  output logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic [DW-1:0] y_out,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

  fir_state_e    state_q,   state_d;
  logic          hist_en_q, hist_en_d;
  logic [DW-1:0] hist_din_q, hist_din_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] y_out_q,   y_out_d;
  logic          y_valid_q, y_valid_d;
  logic          busy_q,    busy_d;

  logic          mac_clr_s;
  logic          mac_en_s;
  logic [DW-1:0] y_next_s;

  // MAC control. Read data trails the address by one cycle, so the first MAC
  // cycle (address 0 just issued) has nothing to accumulate; DRAIN picks up
  // the product for the last address.
  always_comb begin
    mac_clr_s = (state_q == ST_SETTLE);
    mac_en_s  = ((state_q == ST_MAC) && (addr_q != '0)) ||
                (state_q == ST_DRAIN);
  end

  fir_mac #(
    .DW    (DW),
    .CW    (CW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .a      (hist_dout),
    .b      (coef_data),
    .y_next (y_next_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    hist_en_d  = 1'b0;
    hist_din_d = hist_din_q;
    addr_d     = addr_q;
    y_out_d    = y_out_q;
    y_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          hist_din_d = sample_in;
          hist_en_d  = 1'b1;
          state_d    = ST_PUSH;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_PUSH: begin
        // Address 0 is presented during SETTLE and the first MAC cycle.
        addr_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d  = addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        // y_next_s already includes the final product accumulated this cycle.
        y_out_d   = y_next_s;
        y_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hist_en_q  <= 1'b0;
      hist_din_q <= '0;
      addr_q     <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_en_q  <= hist_en_d;
      hist_din_q <= hist_din_d;
      addr_q     <= addr_d;
      y_out_q    <= y_out_d;
      y_valid_q  <= y_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign hist_en   = hist_en_q;
  assign hist_din  = hist_din_q;
  assign hist_addr = addr_q;
  assign coef_addr = addr_q;
  assign y_out     = y_out_q;
  assign y_valid   = y_valid_q;
  assign busy      = busy_q;
  // The drop must be flagged in the cycle the strobe arrives, so this is the
  // one output decoded combinationally from the input and registered busy.
  assign overrun   = sample_valid & busy_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_in = 32'd0;
  logic        hist_en;
  logic [31:0] hist_din;
  logic [6:0]  hist_addr;
  logic [31:0] hist_dout;
  logic [6:0]  coef_addr;
  logic [15:0] coef_data;
  logic [31:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic [31:0] hist_mem [0:65];
  logic [15:0] coef_mem [0:65];
  logic        hist_en_prev;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .hist_en      (hist_en),
    .hist_din     (hist_din),
    .hist_addr    (hist_addr),
    .hist_dout    (hist_dout),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // History buffer (shifts on a rising hist_en) and coefficient ROM, both
  // with registered 1-cycle reads.
  always @(posedge clk) begin
    hist_en_prev <= hist_en;
    if (hist_en && !hist_en_prev) begin
      for (int k = 65; k > 0; k--) hist_mem[k] <= hist_mem[k-1];
      hist_mem[0] <= hist_din;
    end
    hist_dout <= (hist_addr < 7'd66) ? hist_mem[hist_addr] : 32'd0;
    coef_data <= (coef_addr < 7'd66) ? coef_mem[coef_addr] : 16'd0;
  end

  task automatic clear_hist();
    for (int k = 0; k < 66; k++) hist_mem[k] = 32'd0;
  endtask

  task automatic set_coef_ramp();
    for (int k = 0; k < 66; k++) coef_mem[k] = 16'(k + 1);
  endtask

  task automatic set_coef_const(input logic [15:0] c);
    for (int k = 0; k < 66; k++) coef_mem[k] = c;
  endtask

  // One sample, then 79 more cycles; returns the last y_out seen with
  // y_valid and the number of y_valid pulses.
  task automatic run_sample(input logic [31:0] x, output logic [31:0] y, output int nvalid);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = x;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = 32'd0;
    nvalid = 0;
    y = 32'd0;
    for (int c = 1; c < 80; c++) begin
      if (y_valid) begin
        nvalid++;
        y = y_out;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({hist_en, y_valid, busy, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {hist_en, y_valid, busy, overrun});
    end
    checks++;
    if ({hist_din, y_out, hist_addr, coef_addr} !== 78'd0) begin
      failures++;
      $display("FAIL reset_data: got din=%h y=%h ha=%0d ca=%0d expected all 0",
               hist_din, y_out, hist_addr, coef_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timing();
    logic hen_exp, yv_exp, busy_exp;
    set_coef_ramp();
    clear_hist();
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 32'd100;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      hen_exp  = (c == 1);
      yv_exp   = (c == 70);
      busy_exp = (c <= 70);
      checks++;
      if ({hist_en, y_valid, busy} !== {hen_exp, yv_exp, busy_exp}) begin
        failures++;
        $display("FAIL timing_c%0d: got hen/yv/busy=%b expected %b", c,
                 {hist_en, y_valid, busy}, {hen_exp, yv_exp, busy_exp});
      end
      if (c == 3 || c == 68 || c == 75) begin
        checks++;
        if (hist_addr !== ((c == 3) ? 7'd0 : 7'd65) || coef_addr !== hist_addr) begin
          failures++;
          $display("FAIL timing_addr_c%0d: got ha=%0d ca=%0d expected %0d", c,
                   hist_addr, coef_addr, (c == 3) ? 0 : 65);
        end
      end
      if (c == 70) begin
        // 100 * coef[0]=1 -> (100 + 16384) >> 15 = 0
        checks++;
        if (y_out !== 32'd0) begin
          failures++;
          $display("FAIL timing_y: got %0d expected 0", $signed(y_out));
        end
      end
    end
  endtask

  task automatic test_impulse();
    logic [31:0] y;
    logic [31:0] exp_y;
    int nv;
    set_coef_ramp();
    clear_hist();
    for (int n = 0; n <= 66; n++) begin
      run_sample((n == 0) ? 32'd32768 : 32'd0, y, nv);
      exp_y = (n < 66) ? 32'(n + 1) : 32'd0;
      checks++;
      if (nv !== 1 || y !== exp_y) begin
        failures++;
        $display("FAIL impulse_%0d: got y=%0d pulses=%0d expected y=%0d pulses=1",
                 n, $signed(y), nv, exp_y);
      end
    end
  endtask

  task automatic test_dc();
    logic [31:0] y;
    int nv;
    set_coef_const(16'h0100);
    clear_hist();
    for (int n = 0; n < 68; n++) begin
      run_sample(32'd128, y, nv);
      // each filled tap contributes 128*256 = 32768 = one output LSB
      checks++;
      if (nv !== 1 || y !== 32'((n < 66) ? n + 1 : 66)) begin
        failures++;
        $display("FAIL dc_%0d: got y=%0d pulses=%0d expected y=%0d pulses=1",
                 n, $signed(y), nv, (n < 66) ? n + 1 : 66);
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] y;
    int nv;
    set_coef_ramp();
    clear_hist();
    nv = 0;
    y = 32'd0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 32'd32768;
    for (int c = 1; c < 80; c++) begin
      @(negedge clk);
      sample_valid = (c == 10 || c == 70);
      sample_in    = (c == 10 || c == 70) ? 32'h0001_2345 : 32'd0;
      #1;
      if (c == 10 || c == 70 || c == 11) begin
        checks++;
        if (overrun !== (c != 11)) begin
          failures++;
          $display("FAIL overrun_c%0d: got %b expected %b", c, overrun, (c != 11));
        end
      end
      if (c == 72) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL overrun_out_drop: got busy=%b expected 0", busy);
        end
      end
      if (y_valid) begin
        nv++;
        y = y_out;
      end
    end
    sample_valid = 1'b0;
    checks++;
    if (nv !== 1 || y !== 32'd1) begin
      failures++;
      $display("FAIL overrun_result: got y=%0d pulses=%0d expected y=1 pulses=1", $signed(y), nv);
    end
    checks++;
    if (hist_mem[0] !== 32'd32768 || hist_mem[1] !== 32'd0) begin
      failures++;
      $display("FAIL overrun_push: got h0=%h h1=%h expected 00008000 00000000",
               hist_mem[0], hist_mem[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] y;
    int nv;
    set_coef_ramp();
    clear_hist();
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 32'd32768;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hist_en, y_valid, busy, overrun, hist_din, y_out, hist_addr, coef_addr} !== 82'd0) begin
      failures++;
      $display("FAIL reset_mid: got hen=%b yv=%b busy=%b ov=%b din=%h y=%h ha=%0d expected all 0",
               hist_en, y_valid, busy, overrun, hist_din, y_out, hist_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (y_valid) nv++;
    end
    checks++;
    if (nv !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_valid: got %0d pulses expected 0", nv);
    end
    // aborted sample stays in the buffer: tap 1 now holds 32768, coef 2
    run_sample(32'd0, y, nv);
    checks++;
    if (nv !== 1 || y !== 32'd2) begin
      failures++;
      $display("FAIL reset_mid_next: got y=%0d pulses=%0d expected y=2 pulses=1", $signed(y), nv);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] y;
    logic [31:0] exp_y;
    longint acc;
    longint sh;
    int nv;
    set_coef_const(16'h7FFF);
    clear_hist();
    for (int n = 1; n <= 66; n++) begin
      run_sample(32'h7FFF_FFFF, y, nv);
      acc = longint'(n) * 64'sd32767 * 64'sd2147483647;
      sh  = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
      exp_y = (sh > 64'sd2147483647) ? 32'h7FFF_FFFF : sh[31:0];
`else
      exp_y = sh[31:0];
`endif
      if (n == 1 || n == 2 || n == 66) begin
        checks++;
        if (nv !== 1 || y !== exp_y) begin
          failures++;
          $display("FAIL saturation_%0d: got y=%h pulses=%0d expected y=%h pulses=1",
                   n, y, nv, exp_y);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_impulse();
    test_dc();
    test_overrun();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
